// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key-schedule engine: mode encodings,
// key-size lookups, GF(2^8) doubling and the controller state type.
package aes_key_pkg;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Key length in 32-bit words.
  function automatic logic [3:0] nk_of(input logic [1:0] mode);
    case (mode)
      MODE_192: nk_of = 4'd6;
      MODE_256: nk_of = 4'd8;
      default:  nk_of = 4'd4;
    endcase
  endfunction

  // Number of cipher rounds.
  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      MODE_192: nr_of = 4'd12;
      MODE_256: nr_of = 4'd14;
      default:  nr_of = 4'd10;
    endcase
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: row nibble and column nibble select one table byte.
module aes_sbox (
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [7:0] sub
);

  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte lookup; table entry n occupies bits [8n : 8n+7].
  always_comb begin
    sub = SBOX_TABLE[{row, col, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_subword.sv
// SubWord: applies the S-box to each byte of a 32-bit word.
module aes_subword (
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  aes_sbox u_sbox3 (.row(word_in[31:28]), .col(word_in[27:24]), .sub(word_out[31:24]));
  aes_sbox u_sbox2 (.row(word_in[23:20]), .col(word_in[19:16]), .sub(word_out[23:16]));
  aes_sbox u_sbox1 (.row(word_in[15:12]), .col(word_in[11:8]),  .sub(word_out[15:8]));
  aes_sbox u_sbox0 (.row(word_in[7:4]),   .col(word_in[3:0]),   .sub(word_out[7:0]));

endmodule

// File: rtl/aes_key_expand.sv
// Sequential AES-128/192/256 key schedule: one expanded word per cycle,
// round keys 0..Nr delivered in order over a valid/ready stream.
module aes_key_expand
  import aes_key_pkg::*;
#(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [0:255] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [0:127] rk_data,
  output logic [3:0]   rk_index,
  output logic         done
);

  state_t       state;
  logic [5:0]   word_idx;    // i: index of the word produced this cycle
  logic [2:0]   phase;       // i mod Nk, kept as a wrapping counter
  logic [7:0]   rcon;
  logic [0:255] key_r;
  logic [1:0]   mode_r;
  logic [31:0]  win [8];     // win[7] = w[i-1] ... win[0] = w[i-8]
  logic [31:0]  coll [3];    // w[4r .. 4r+2] of the key being assembled

  logic [3:0]   nk;
  logic [3:0]   nr;
  logic [5:0]   last_word;
  logic         mode_ok;
  logic         stall;
  logic [31:0]  prev_word;
  logic [31:0]  back_word;
  logic [31:0]  sub_in;
  logic [31:0]  sub_out;
  logic [31:0]  temp_word;
  logic [31:0]  w_new;

  aes_subword u_subword (.word_in(sub_in), .word_out(sub_out));

  // Next expanded word; the single SubWord unit serves both the RotWord
  // step (i mod Nk == 0) and the AES-256 mid-block step (i mod 8 == 4).
  always_comb begin
    nk        = nk_of(mode_r);
    nr        = nr_of(mode_r);
    last_word = {nr, 2'b11};
    mode_ok   = (mode == MODE_128) ||
                ((mode == MODE_192) && SUPPORT_192) ||
                ((mode == MODE_256) && SUPPORT_256);
    stall     = (word_idx[1:0] == 2'b11) && rk_valid && !rk_ready;
    prev_word = win[7];
    sub_in    = (phase == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    case (nk)
      4'd4:    back_word = win[4];
      4'd6:    back_word = win[2];
      default: back_word = win[0];
    endcase
    temp_word = prev_word;
    if (phase == 3'd0) begin
      temp_word = sub_out ^ {rcon, 24'h000000};
    end else if ((nk == 4'd8) && (phase == 3'd4)) begin
      temp_word = sub_out;
    end
    if (word_idx < {2'b00, nk}) begin
      w_new = key_r[{word_idx[2:0], 5'b00000} +: 32];
    end else begin
      w_new = back_word ^ temp_word;
    end
  end

  // Controller, expansion registers and round-key output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      word_idx <= '0;
      phase    <= '0;
      rcon     <= 8'h01;
      key_r    <= '0;
      mode_r   <= MODE_128;
      for (int unsigned k = 0; k < 8; k++) win[k] <= '0;
      for (int unsigned k = 0; k < 3; k++) coll[k] <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      done     <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      // A load later in this block overrides the clear, so a transfer and
      // a new key in the same cycle leave no bubble.
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode_ok) begin
              key_r    <= key_in;
              mode_r   <= mode;
              word_idx <= '0;
              phase    <= '0;
              rcon     <= 8'h01;
              busy     <= 1'b1;
              state    <= EXPAND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        EXPAND: begin
          if (!stall) begin
            for (int unsigned k = 0; k < 7; k++) win[k] <= win[k+1];
            win[7]   <= w_new;
            word_idx <= word_idx + 6'd1;
            phase    <= ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
            if ((phase == 3'd0) && (word_idx >= {2'b00, nk})) rcon <= xtime(rcon);
            case (word_idx[1:0])
              2'b00: coll[0] <= w_new;
              2'b01: coll[1] <= w_new;
              2'b10: coll[2] <= w_new;
              default: begin
                rk_data  <= {coll[0], coll[1], coll[2], w_new};
                rk_index <= word_idx[5:2];
                rk_valid <= 1'b1;
                if (word_idx == last_word) state <= DRAIN;
              end
            endcase
          end
        end
        DRAIN: begin
          if (rk_valid && rk_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: an independent FIPS-197 key
// expansion (S-box derived from GF(2^8) inversion) predicts every round key.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start, start2, rk_ready;
  logic [1:0]   mode;
  logic [0:255] key_in;
  logic         busy, err, rk_valid, done;
  logic [0:127] rk_data;
  logic [3:0]   rk_index;
  logic         busy2, err2, rk_valid2, done2;
  logic [0:127] rk_data2;
  logic [3:0]   rk_index2;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_data(rk_data), .rk_index(rk_index), .done(done)
  );

  aes_key_expand #(.SUPPORT_192(1'b1), .SUPPORT_256(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode), .key_in(key_in),
    .busy(busy2), .err(err2), .rk_valid(rk_valid2), .rk_ready(rk_ready),
    .rk_data(rk_data2), .rk_index(rk_index2), .done(done2)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  localparam logic [7:0] RC_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           xfer_cnt = 0;
  logic [7:0]   sb [256];
  logic [31:0]  mw [60];
  logic [127:0] cap [16];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gf_mul(8'(v), 8'(x)) == 8'h01) inv = 8'(x);
      sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic int nr_for(input logic [1:0] m);
    return (m == 2'b00) ? 10 : (m == 2'b01) ? 12 : 14;
  endfunction

  // Textbook expansion; pushes every expected round key onto the scoreboard.
  task automatic expand_model(input logic [1:0] m, input logic [255:0] k);
    int nk, nr;
    logic [31:0] t;
    exp_t e;
    nr = nr_for(m);
    nk = nr - 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        mw[i] = k[255 - 32*i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {RC_TAB[i/nk - 1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = subw(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) begin
      e.idx  = 4'(r);
      e.data = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  // Transfer monitor: pops the scoreboard on each handshake, checks hold.
  always @(negedge clk) begin
    exp_t e;
    if (rk_valid && prev_stall) check("stable", rk_data, prev_data);
    if (rk_valid && rk_ready) begin
      check("q_nonempty", 128'(exp_q.size() > 0), 128'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rk_data", rk_data, e.data);
        check("rk_index", 128'(rk_index), 128'(e.idx));
      end
      cap[rk_index] = rk_data;
      xfer_cnt++;
    end
    prev_stall = rk_valid && !rk_ready;
    prev_data  = rk_data;
  end

  task automatic run_key(input logic [1:0] m, input logic [255:0] k, input int ready_pct,
                         input int exp_done_n, input bit poke_busy);
    int n = 0;
    int first_n = 0;
    int done_n = 0;
    expand_model(m, k);
    xfer_cnt = 0;
    mode = m; key_in = k; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_rise", 128'(busy), 128'd1);
    while (done_n == 0 && n < 400) begin
      n++;
      rk_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < 32'(ready_pct));
      if (poke_busy) begin
        if (n == 10) begin start = 1'b1; mode = 2'b01; key_in = '1; end
        else start = 1'b0;
      end
      @(posedge clk); #1;
      if (rk_valid && first_n == 0) first_n = n;
      if (done) begin
        done_n = n;
        check("busy_fall", 128'(busy), 128'd0);
      end
    end
    start = 1'b0;
    check("done_seen", 128'(done_n != 0), 128'd1);
    if (exp_done_n > 0) begin
      check("done_cycle", 128'(done_n), 128'(exp_done_n));
      check("first_key_cycle", 128'(first_n), 128'd4);
    end
    check("xfer_count", 128'(xfer_cnt), 128'(nr_for(m) + 1));
    check("q_empty", 128'(exp_q.size()), 128'd0);
    @(posedge clk); #1;
    check("done_pulse", 128'(done), 128'd0);
    rk_ready = 1'b1;
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; rk_ready = 1'b0;
    mode = 2'b00; key_in = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", 128'({busy, err, rk_valid, done, rk_index}), 128'd0);
    check("rst_data", rk_data, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_key(2'b00, KEY128, 100, 45, 1'b0);
    check("aes128_rk1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key(2'b01, KEY192, 100, 53, 1'b0);
    check("aes192_rk12", cap[12], 128'he98ba06f448c773c8ecc720401002202);

    run_key(2'b10, KEY256, 100, 61, 1'b0);
    check("aes256_rk14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Invalid mode on both instances, 256 on the instance lacking it.
    mode = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", 128'({err, busy}), 128'b10);
    @(posedge clk); #1;
    check("err_clear", 128'({err, busy}), 128'b00);
    mode = 2'b10; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    check("err2_pulse", 128'({err2, busy2}), 128'b10);
    @(posedge clk); #1;
    check("err2_clear", 128'({err2, busy2, rk_valid2}), 128'b000);

    run_key(2'b00, KEY128, 30, 0, 1'b1);

    // Reset mid AES-256 run.
    expand_model(2'b10, KEY256);
    mode = 2'b10; key_in = KEY256; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_ctrl", 128'({busy, err, rk_valid, done, rk_index}), 128'd0);
    check("midrst_data", rk_data, 128'd0);
    saw_done = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done || busy || rk_valid) saw_done = 1'b1;
    end
    check("midrst_quiet", 128'(saw_done), 128'd0);

    run_key(2'b00, KEY128, 100, 45, 1'b0);
    check("post_rst_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Sequential AES key-schedule engine generalising the single-round, AES-128-only round-key generator to AES-128/192/256. It expands the cipher key one 32-bit word per cycle and delivers the round keys 0..Nr in order as 128-bit words over a valid/ready stream. It sits between key load and the round datapath, which consumes one round key per round.

## Interface
- SUPPORT_192, default 1: mode 2'b01 is accepted; when 0 it is treated as invalid.
- SUPPORT_256, default 1: mode 2'b10 is accepted; when 0 it is treated as invalid.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- mode  in  2  2'b00 AES-128, 2'b01 AES-192, 2'b10 AES-256; 2'b11 is invalid.
- key_in  in  [0:255]  cipher key, big-endian bit order; word j = key_in[32j:32j+31]. AES-128 uses [0:127]; AES-192 uses [0:191].
- busy  out  1  high from the accepted start until done.
- err  out  1  one-cycle pulse when start arrives with an invalid or unsupported mode.
- rk_valid  out  1  rk_data/rk_index hold a round key.
- rk_ready  in  1  consumer accepts; transfer when rk_valid && rk_ready.
- rk_data  out  [0:127]  round key, words w[4r..4r+3].
- rk_index  out  4  round number r, 0..Nr.
- done  out  1  one-cycle pulse after round key Nr transfers.

## Operation
- Key sizes: Nk = 4/6/8 and Nr = 10/12/14; total words W = 4(Nr+1) = 44/52/60.
- States:
  - IDLE: start with a valid mode latches key_in and mode, sets word counter i=0 and rcon=8'h01, and moves to EXPAND. An invalid mode pulses err and stays in IDLE. start outside IDLE is ignored.
  - EXPAND: one word per non-stalled cycle.
    - i < Nk: w[i] = key word i.
    - Otherwise w[i] = w[i-Nk] ^ t, with t = w[i-1], modified as follows:
      - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}, then rcon <= xtime(rcon).
      - If Nk == 8 and i mod Nk == 4: t = SubWord(t).
    - An 8-word shift window holds w[i-8..i-1].
    - A 3-word collector holds w[4r..4r+2].
    - When i mod 4 == 3, rk_data is loaded with {collector, w[i]}, rk_index is set to i>>2, and rk_valid is set.
    - After word W-1 the state moves to DRAIN.
  - DRAIN: wait for the final transfer, then pulse done, drop busy, and return to IDLE.
- Backpressure: generation stalls for any cycle where i mod 4 == 3 and rk_valid && !rk_ready. If a transfer and a new load coincide, the new key is loaded; there is no bubble.
- rk_valid clears on a transfer unless a new key is loaded in the same cycle.
- rk_data is stable while rk_valid && !rk_ready.
- xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).

## Timing
- Reset values: busy=0, err=0, rk_valid=0, rk_data=0, rk_index=0, done=0. State is IDLE, i=0, rcon=8'h01, window and collector zero.
- A reset mid-expansion aborts immediately with no done pulse.
- start is sampled at edge E0. Word i is written at edge E(i+1). Round key 0 is valid after E4.
- With rk_ready held high, key r is valid after E(4r+4), giving one key every 4 cycles.
- AES-128: last key after E44, transferred at E45, done high in the cycle after E45.
- AES-192 and AES-256: the last key is valid after E52 and E60 respectively.
- busy rises after E0 and falls together with the done pulse.
- err rises after the sampling edge and lasts one cycle.

## Structure
- Package aes_key_pkg holds:
  - mode encoding constants;
  - NK/NR lookup functions per mode;
  - function xtime;
  - the state enum (IDLE, EXPAND, DRAIN).
- Sub-module aes_subword: four instances of the existing sbox (row nibble, column nibble → byte), purely combinational, 32 bits in and 32 bits out. One instance is shared by both the RotWord and the i mod 8 == 4 paths.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk_index 1 = a0fafe1788542cb123a339392a6c7605, rk_index 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done high in the cycle after E45.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → rk_index 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → rk_index 14 = fe4890d1e6188d0b046df344706c631e.
- AES-128 with rk_ready random at 30% → the same 11 keys in order, rk_data stable while stalled, no key lost or duplicated.
- mode=2'b11, or mode=2'b10 with SUPPORT_256=0 → err pulses, busy stays 0. start while busy → ignored.
- rst asserted at cycle 20 of an AES-256 run → all outputs return to their reset values next cycle, no done. A new AES-128 start then produces correct keys.
